// File: rtl/sawtooth_seq_ctrl.sv
// Phase-accumulator sequencer for a 10-bit-address, 4-bit-select sawtooth LUT.
// Optional amplitude scaling is enabled by defining SAWTOOTH_AMP_SCALE_EN.
module sawtooth_seq_ctrl #(
  parameter int ACC_W   = 24,
  parameter int ADDR_W  = 10,
  parameter int SEL_W   = 4,
  parameter int SEL_MAX = 10,
  parameter int DATA_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ACC_W-1:0]  i_fcw,
  input  logic              i_sel_wr,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_lut_data,
`ifdef SAWTOOTH_AMP_SCALE_EN
  input  logic [7:0]        i_amp,
`endif
  output logic [ADDR_W-1:0] o_lut_addr,
  output logic [SEL_W-1:0]  o_lut_sel,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_wrap,
  output logic              o_sel_err,
  output logic              o_busy,
  output logic              o_dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [SEL_W-1:0] SEL_MAX_V = SEL_W'(SEL_MAX);

  logic [0:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  fcw_q, fcw_d;
  logic [SEL_W-1:0]  active_sel_q, active_sel_d;
  logic [SEL_W-1:0]  shadow_sel_q, shadow_sel_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              sel_err_q, sel_err_d;
  logic              stop_pend_q, stop_pend_d;

  logic [ACC_W:0]    sum;
  logic              sel_legal;
  logic              advance;
  logic              wrap;
  logic [DATA_W-1:0] sample_calc;

`ifdef SAWTOOTH_AMP_SCALE_EN
  logic [7:0]        amp_q, amp_d;
  logic [DATA_W+7:0] prod;
  always_comb begin
    prod        = {8'b0, i_lut_data} * {{DATA_W{1'b0}}, amp_q};
    sample_calc = prod[DATA_W+7:8];
  end
`else
  assign sample_calc = i_lut_data;
`endif

  // Handshake: a sample transfers on a cycle where o_valid & i_ready; o_sample is
  // held stable while o_valid is high and i_ready is low, and the phase stalls with it.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fcw_d        = fcw_q;
    active_sel_d = active_sel_q;
    sample_d     = sample_q;
    valid_d      = valid_q;
    stop_pend_d  = stop_pend_q;
`ifdef SAWTOOTH_AMP_SCALE_EN
    amp_d        = amp_q;
`endif
    sum          = {1'b0, acc_q} + {1'b0, fcw_q};
    sel_legal    = (i_sel <= SEL_MAX_V);
    shadow_sel_d = (i_sel_wr && sel_legal) ? i_sel : shadow_sel_q;
    sel_err_d    = i_sel_wr && !sel_legal;
    advance      = (state_q == ST_RUN) && (!valid_q || i_ready);
    wrap         = advance && sum[ACC_W];

    case (state_q)
      ST_IDLE: begin
        if (valid_q && i_ready) valid_d = 1'b0;
        if (i_start) begin
          acc_d        = '0;
          fcw_d        = i_fcw;
          active_sel_d = shadow_sel_q;
          stop_pend_d  = 1'b0;
          state_d      = ST_RUN;
`ifdef SAWTOOTH_AMP_SCALE_EN
          amp_d        = i_amp;
`endif
        end
      end
      ST_RUN: begin
        if (i_stop) stop_pend_d = 1'b1;
        if (advance) begin
          sample_d = sample_calc;
          valid_d  = 1'b1;
          acc_d    = sum[ACC_W-1:0];
        end
        // Parameter changes land only on the wrapping advance so a period is never torn.
        if (wrap) begin
          fcw_d        = i_fcw;
          active_sel_d = shadow_sel_d;
`ifdef SAWTOOTH_AMP_SCALE_EN
          amp_d        = i_amp;
`endif
          if (stop_pend_q || i_stop) begin
            state_d     = ST_IDLE;
            stop_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      fcw_q        <= '0;
      active_sel_q <= '0;
      shadow_sel_q <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      sel_err_q    <= 1'b0;
      stop_pend_q  <= 1'b0;
`ifdef SAWTOOTH_AMP_SCALE_EN
      amp_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fcw_q        <= fcw_d;
      active_sel_q <= active_sel_d;
      shadow_sel_q <= shadow_sel_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      sel_err_q    <= sel_err_d;
      stop_pend_q  <= stop_pend_d;
`ifdef SAWTOOTH_AMP_SCALE_EN
      amp_q        <= amp_d;
`endif
    end
  end

  assign o_lut_addr  = acc_q[ACC_W-1 -: ADDR_W];
  assign o_lut_sel   = active_sel_q;
  assign o_sample    = sample_q;
  assign o_valid     = valid_q;
  assign o_wrap      = wrap;
  assign o_sel_err   = sel_err_q;
  assign o_busy      = (state_q == ST_RUN) || valid_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sawtooth_seq_ctrl.sv
// Scoreboard bench for sawtooth_seq_ctrl: a phase/period model predicts samples,
// address, select and control pulses; a monitor pops expected samples on each transfer.
module tb_sawtooth_seq_ctrl;
  localparam int     SEL_MAX = 10;
  localparam longint MOD     = longint'(1) << 24;
  localparam longint STEP    = MOD / 1024;
  localparam longint FCW1    = longint'(1) << 14;

  logic        clk;
  logic        i_rst_n;
  logic        i_start, i_stop, i_sel_wr, i_ready;
  logic [23:0] i_fcw;
  logic [3:0]  i_sel;
  logic [15:0] i_lut_data;
  logic [9:0]  o_lut_addr;
  logic [3:0]  o_lut_sel;
  logic [15:0] o_sample;
  logic        o_valid, o_wrap, o_sel_err, o_busy, o_dbg_state;
`ifdef SAWTOOTH_AMP_SCALE_EN
  logic [7:0]  i_amp;
  initial i_amp = 8'd128;
`endif

  sawtooth_seq_ctrl dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_fcw(i_fcw), .i_sel_wr(i_sel_wr), .i_sel(i_sel), .i_lut_data(i_lut_data),
`ifdef SAWTOOTH_AMP_SCALE_EN
    .i_amp(i_amp),
`endif
    .o_lut_addr(o_lut_addr), .o_lut_sel(o_lut_sel), .o_sample(o_sample),
    .o_valid(o_valid), .i_ready(i_ready), .o_wrap(o_wrap), .o_sel_err(o_sel_err),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT stand-in: unique value per (addr, sel); select 0 is flat zero
  function automatic logic [15:0] lut_fn(input logic [9:0] a, input logic [3:0] s);
    return (s == 4'd0) ? 16'h0000 : {s, a, 2'b11};
  endfunction
  assign i_lut_data = lut_fn(o_lut_addr, o_lut_sel);

  function automatic logic [15:0] exp_sample(input longint addr, input int sel);
    logic [15:0] v;
    v = lut_fn(10'(addr), 4'(sel));
`ifdef SAWTOOTH_AMP_SCALE_EN
    v = 16'((int'(v) * 128) / 256);
`endif
    return v;
  endfunction

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  logic [15:0] exp_q[$];

  // reference model state
  bit     m_run, m_valid, m_stop_pend, m_err;
  longint m_phase, m_fcw;
  int     m_active, m_shadow;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_valid = 0; m_stop_pend = 0; m_err = 0;
    m_phase = 0; m_fcw = 0; m_active = 0; m_shadow = 0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit st, input bit sp, input longint f, input bit sw,
                      input int s, input bit rdy);
    bit     adv, wr;
    longint tot;
    int     new_shadow;
    @(negedge clk);
    i_start = st; i_stop = sp; i_fcw = f[23:0]; i_sel_wr = sw; i_sel = s[3:0]; i_ready = rdy;
    #1;
    adv = m_run && (!m_valid || rdy);
    tot = m_phase + m_fcw;
    wr  = adv && (tot >= MOD);
    chk("lut_addr", 32'(o_lut_addr), 32'(m_phase / STEP));
    chk("lut_sel",  32'(o_lut_sel),  32'(m_active));
    chk("valid",    32'(o_valid),    32'(m_valid));
    chk("busy",     32'(o_busy),     32'(m_run || m_valid));
    chk("wrap",     32'(o_wrap),     32'(wr));
    chk("sel_err",  32'(o_sel_err),  32'(m_err));
    chk("state",    32'(o_dbg_state), 32'(m_run));
    new_shadow = (sw && s <= SEL_MAX) ? s : m_shadow;
    m_err = sw && (s > SEL_MAX);
    if (m_run) begin
      if (adv) begin
        exp_q.push_back(exp_sample(m_phase / STEP, m_active));
        m_valid = 1;
        m_phase = tot % MOD;
        if (wr) begin
          m_fcw = f;
          m_active = new_shadow;
        end
      end
      if (wr && (m_stop_pend || sp)) begin
        m_run = 0;
        m_stop_pend = 0;
      end else if (sp) begin
        m_stop_pend = 1;
      end
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (st) begin
        m_phase = 0; m_fcw = f; m_active = m_shadow; m_stop_pend = 0; m_run = 1;
      end
    end
    m_shadow = new_shadow;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 0; i_start = 0; i_stop = 0; i_sel_wr = 0; i_ready = 0;
    #1;
    chk("rst_addr",   32'(o_lut_addr), 0);
    chk("rst_sel",    32'(o_lut_sel),  0);
    chk("rst_sample", 32'(o_sample),   0);
    chk("rst_valid",  32'(o_valid),    0);
    chk("rst_wrap",   32'(o_wrap),     0);
    chk("rst_selerr", 32'(o_sel_err),  0);
    chk("rst_busy",   32'(o_busy),     0);
    chk("rst_state",  32'(o_dbg_state), 0);
    model_clear();
    repeat (3) @(negedge clk);
    i_rst_n = 1;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (i_rst_n && o_valid && i_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sample_unexpected: got %0d expected none at %0t", o_sample, $time);
        end else begin
          chk("sample", 32'(o_sample), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int p0;
    i_rst_n = 0; i_start = 0; i_stop = 0; i_sel_wr = 0; i_sel = 0; i_ready = 0; i_fcw = 0;
    model_clear();
    do_reset();

    // directed: fcw=1<<14 gives one address per advance, 1024-sample periods
    step(0, 0, FCW1, 1, 5, 1);
    p0 = n_pops;
    step(1, 0, FCW1, 0, 0, 1);
    for (int i = 0; i < 3000 && !(m_phase / STEP == 500); i++) step(0, 0, FCW1, 0, 0, 1);
    step(0, 0, FCW1, 1, 3, 1);
    for (int i = 0; i < 3000 && !(m_phase / STEP == 600); i++) step(0, 0, FCW1, 0, 0, 1);
    step(0, 0, FCW1, 1, 12, 1);
    for (int i = 0; i < 3000 && !(m_phase / STEP == 700); i++) step(0, 0, FCW1, 0, 0, 1);
    repeat (7) step(0, 0, FCW1, 0, 0, 0);
    for (int i = 0; i < 3000 && !(m_active == 3 && m_phase / STEP == 100); i++)
      step(0, 0, FCW1, 0, 0, 1);
    step(0, 1, FCW1, 0, 0, 1);
    for (int i = 0; i < 3000 && (m_run || m_valid); i++) step(0, 0, FCW1, 0, 0, 1);
    step(0, 0, FCW1, 0, 0, 1);
    chk("directed_samples", 32'(n_pops - p0), 32'd2048);

    // fcw=0: phase frozen, stop never completes, only reset exits
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, (i == 5), 0, 0, 0, (i % 3) != 0);
    do_reset();

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           longint'($urandom_range(1 << 19, 1 << 21)), $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 400 && (m_run || m_valid); i++)
      step(0, 1, longint'(1) << 20, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("final_busy", 32'(o_busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
